// File: rtl/sdft_pkg.sv
// Shared types and helpers for the sdft spectral pipeline and its downstream stages.
// No logic of its own; imported by sdft_mag2 and sdft_peak_finder.
package sdft_pkg;

  typedef enum logic {
    PF_IDLE  = 1'b0,
    PF_FRAME = 1'b1
  } pf_state_t;

  typedef struct packed {
    logic vld;
    logic sob;
    logic eob;
  } beat_ctl_t;

  function automatic int mag2_width(input int idw);
    return 2 * idw + 1;
  endfunction

endpackage

// File: rtl/sdft_mag2.sv
// Squared magnitude re^2 + im^2 at full precision, with the beat sideband carried alongside.
// Latency 2 cycles (products, then sum). No backpressure: accepts one beat per cycle.
module sdft_mag2
  import sdft_pkg::*;
#(
  parameter int IDW = 32,
  parameter int TW  = 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [IDW-1:0]   re_i,
  input  logic [IDW-1:0]   im_i,
  input  logic             valid_i,
  input  logic             sob_i,
  input  logic             eob_i,
  input  logic [TW-1:0]    tag_i,
  output logic [2*IDW:0]   mag_o,
  output logic             valid_o,
  output logic             sob_o,
  output logic             eob_o,
  output logic [TW-1:0]    tag_o
);

  logic signed [2*IDW-1:0] re_ext, im_ext;
  logic [2*IDW-1:0]        re_sq_d, re_sq_q, im_sq_d, im_sq_q;
  logic [2*IDW:0]          mag_d, mag_q;
  beat_ctl_t               ctl1_d, ctl1_q, ctl2_d, ctl2_q;
  logic [TW-1:0]           tag1_d, tag1_q, tag2_d, tag2_q;

  // Sign-extend first so the product is formed at the full 2*IDW width.
  always_comb begin
    re_ext     = {{IDW{re_i[IDW-1]}}, re_i};
    im_ext     = {{IDW{im_i[IDW-1]}}, im_i};
    re_sq_d    = re_ext * re_ext;
    im_sq_d    = im_ext * im_ext;
    ctl1_d.vld = valid_i;
    ctl1_d.sob = valid_i & sob_i;
    ctl1_d.eob = valid_i & eob_i;
    tag1_d     = tag_i;
    mag_d      = {1'b0, re_sq_q} + {1'b0, im_sq_q};
    ctl2_d     = ctl1_q;
    tag2_d     = tag1_q;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      re_sq_q <= '0;
      im_sq_q <= '0;
      ctl1_q  <= '0;
      tag1_q  <= '0;
      mag_q   <= '0;
      ctl2_q  <= '0;
      tag2_q  <= '0;
    end else begin
      re_sq_q <= re_sq_d;
      im_sq_q <= im_sq_d;
      ctl1_q  <= ctl1_d;
      tag1_q  <= tag1_d;
      mag_q   <= mag_d;
      ctl2_q  <= ctl2_d;
      tag2_q  <= tag2_d;
    end
  end

  assign mag_o   = mag_q;
  assign valid_o = ctl2_q.vld;
  assign sob_o   = ctl2_q.sob;
  assign eob_o   = ctl2_q.eob;
  assign tag_o   = tag2_q;

endmodule

// File: rtl/sdft_peak_finder.sv
// Per-frame strongest-bin finder: emits index/magnitude 3 cycles after eob, flags framing errors.
// No backpressure; one beat per cycle, gaps allowed, back-to-back frames without bubble.
module sdft_peak_finder
  import sdft_pkg::*;
#(
  parameter int BINS = 128,
  parameter int IDW  = 32,
  parameter int IDXW = $clog2(BINS),
  parameter int MW   = mag2_width(IDW)
) (
  input  logic            clk_i,
  input  logic            srst_i,
  input  logic [IDW-1:0]  re_i,
  input  logic [IDW-1:0]  im_i,
  input  logic            valid_i,
  input  logic            sob_i,
  input  logic            eob_i,
  input  logic [MW-1:0]   threshold_i,
  output logic [IDXW-1:0] peak_idx_o,
  output logic [MW-1:0]   peak_mag_o,
  output logic            peak_found_o,
  output logic            peak_valid_o,
  output logic            frame_err_o
);

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic            acc;
    logic            err;
    logic [MW-1:0]   thr;
  } tag_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BINS - 1);

  pf_state_t       state_d, state_q;
  logic [IDXW-1:0] count_d, count_q;
  tag_t            tag_in, tag_s2;
  logic            vld_s2, sob_s2, eob_s2;
  logic [MW-1:0]   mag_s2;

  logic [MW-1:0]   max_mag_d, max_mag_q;
  logic [IDXW-1:0] max_idx_d, max_idx_q;
  logic [IDXW-1:0] peak_idx_d, peak_idx_q;
  logic [MW-1:0]   peak_mag_d, peak_mag_q;
  logic            peak_found_d, peak_found_q;
  logic            peak_valid_d, peak_valid_q;
  logic            frame_err_d, frame_err_q;
  logic            take_s3;

  // Framing decisions are made at entry and ride down the pipe as acc/err tags;
  // a beat with acc=0 never touches the running max.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tag_in     = '0;
    tag_in.idx = count_q;
    tag_in.thr = threshold_i;
    if (valid_i) begin
      case (state_q)
        PF_IDLE: begin
          if (sob_i && eob_i) begin
            tag_in.err = 1'b1;
          end else if (sob_i) begin
            tag_in.acc = 1'b1;
            tag_in.idx = '0;
            count_d    = IDXW'(1);
            state_d    = PF_FRAME;
          end else if (eob_i) begin
            tag_in.err = 1'b1;
          end
        end
        PF_FRAME: begin
          if (sob_i && eob_i) begin
            tag_in.err = 1'b1;
            state_d    = PF_IDLE;
          end else if (sob_i) begin
            tag_in.err = 1'b1;
            tag_in.acc = 1'b1;
            tag_in.idx = '0;
            count_d    = IDXW'(1);
          end else if (count_q == LAST_IDX) begin
            tag_in.acc = eob_i;
            tag_in.err = ~eob_i;
            state_d    = PF_IDLE;
          end else if (eob_i) begin
            tag_in.err = 1'b1;
            state_d    = PF_IDLE;
          end else begin
            tag_in.acc = 1'b1;
            count_d    = count_q + IDXW'(1);
          end
        end
      endcase
    end
  end

  sdft_mag2 #(
    .IDW (IDW),
    .TW  ($bits(tag_t))
  ) u_mag2 (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .re_i    (re_i),
    .im_i    (im_i),
    .valid_i (valid_i),
    .sob_i   (sob_i),
    .eob_i   (eob_i),
    .tag_i   (tag_in),
    .mag_o   (mag_s2),
    .valid_o (vld_s2),
    .sob_o   (sob_s2),
    .eob_o   (eob_s2),
    .tag_o   (tag_s2)
  );

  // Strictly-greater update keeps the lowest index on ties; the eob beat
  // itself may be the winner, so the emitted values use the updated max.
  always_comb begin
    max_mag_d    = max_mag_q;
    max_idx_d    = max_idx_q;
    peak_idx_d   = peak_idx_q;
    peak_mag_d   = peak_mag_q;
    peak_found_d = peak_found_q;
    peak_valid_d = 1'b0;
    take_s3      = vld_s2 && tag_s2.acc;
    if (take_s3 && (sob_s2 || (mag_s2 > max_mag_q))) begin
      max_mag_d = mag_s2;
      max_idx_d = tag_s2.idx;
    end
    if (take_s3 && eob_s2) begin
      peak_valid_d = 1'b1;
      peak_idx_d   = max_idx_d;
      peak_mag_d   = max_mag_d;
      peak_found_d = (max_mag_d >= tag_s2.thr);
    end
    frame_err_d = vld_s2 && tag_s2.err;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q      <= PF_IDLE;
      count_q      <= '0;
      max_mag_q    <= '0;
      max_idx_q    <= '0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
      peak_found_q <= 1'b0;
      peak_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      max_mag_q    <= max_mag_d;
      max_idx_q    <= max_idx_d;
      peak_idx_q   <= peak_idx_d;
      peak_mag_q   <= peak_mag_d;
      peak_found_q <= peak_found_d;
      peak_valid_q <= peak_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign peak_idx_o   = peak_idx_q;
  assign peak_mag_o   = peak_mag_q;
  assign peak_found_o = peak_found_q;
  assign peak_valid_o = peak_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_sdft_peak_finder.sv
// Directed bench for sdft_peak_finder (BINS=8, IDW=16) with hand-computed peaks.
// All clocking goes through step(), which also logs every strobe and its cycle.
module tb_sdft_peak_finder;

  localparam int BINS = 8;
  localparam int IDW  = 16;
  localparam int IDXW = 3;
  localparam int MW   = 33;

  logic            clk = 1'b0;
  logic            srst_i;
  logic [IDW-1:0]  re_i, im_i;
  logic            valid_i, sob_i, eob_i;
  logic [MW-1:0]   threshold_i;
  logic [IDXW-1:0] peak_idx_o;
  logic [MW-1:0]   peak_mag_o;
  logic            peak_found_o, peak_valid_o, frame_err_o;

  always #5 clk = ~clk;

  sdft_peak_finder #(.BINS(BINS), .IDW(IDW)) dut (
    .clk_i        (clk),
    .srst_i       (srst_i),
    .re_i         (re_i),
    .im_i         (im_i),
    .valid_i      (valid_i),
    .sob_i        (sob_i),
    .eob_i        (eob_i),
    .threshold_i  (threshold_i),
    .peak_idx_o   (peak_idx_o),
    .peak_mag_o   (peak_mag_o),
    .peak_found_o (peak_found_o),
    .peak_valid_o (peak_valid_o),
    .frame_err_o  (frame_err_o)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  int pk_n     = 0;
  int err_n    = 0;
  int last_pk_cyc  = -100;
  int last_err_cyc = -100;
  logic [IDXW-1:0] pk_idx_a[16];
  logic [MW-1:0]   pk_mag_a[16];
  int re_v[BINS];
  int im_v[BINS];
  int f_at, l_at, at, at7;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (peak_valid_o) begin
      if (pk_n < 16) begin
        pk_idx_a[pk_n] = peak_idx_o;
        pk_mag_a[pk_n] = peak_mag_o;
      end
      pk_n++;
      last_pk_cyc = cyc;
    end
    if (frame_err_o) begin
      err_n++;
      last_err_cyc = cyc;
    end
  endtask

  task automatic send(input int r, input int i, input logic s, input logic e,
                      input int gap, output int beat_at);
    re_i    = r[IDW-1:0];
    im_i    = i[IDW-1:0];
    valid_i = 1'b1;
    sob_i   = s;
    eob_i   = e;
    beat_at = cyc;
    step();
    valid_i = 1'b0;
    sob_i   = 1'b0;
    eob_i   = 1'b0;
    re_i    = '0;
    im_i    = '0;
    repeat (gap) step();
  endtask

  task automatic send_frame(input logic [MW-1:0] thr, input int maxgap,
                            output int first_at, output int last_at);
    int g, a;
    threshold_i = thr;
    first_at = 0;
    last_at  = 0;
    for (int b = 0; b < BINS; b++) begin
      g = (b == BINS - 1) ? 0 : $urandom_range(0, maxgap);
      send(re_v[b], im_v[b], b == 0, b == BINS - 1, g, a);
      if (b == 0) first_at = a;
      if (b == BINS - 1) last_at = a;
    end
  endtask

  task automatic clear_vec();
    for (int b = 0; b < BINS; b++) begin
      re_v[b] = 0;
      im_v[b] = 0;
    end
  endtask

  initial begin
    srst_i = 1'b1; valid_i = 1'b0; sob_i = 1'b0; eob_i = 1'b0;
    re_i = '0; im_i = '0; threshold_i = '0;
    repeat (3) step();
    check("rst_idx", peak_idx_o, 0);
    check("rst_mag", peak_mag_o, 0);
    check("rst_found", peak_found_o, 0);
    check("rst_valid", peak_valid_o, 0);
    check("rst_err", frame_err_o, 0);
    srst_i = 1'b0;
    step();

    // Tie at bin 4 (25) must not displace bin 2.
    re_v = '{0, 1, 5, 2, 5, 0, 0, 3};
    im_v = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(33'd0, 0, f_at, l_at);
    repeat (6) step();
    check("t1_npk", pk_n, 1);
    check("t1_lat", last_pk_cyc - l_at, 3);
    check("t1_idx", peak_idx_o, 2);
    check("t1_mag", peak_mag_o, 25);
    check("t1_found", peak_found_o, 1);
    check("t1_nerr", err_n, 0);

    send_frame(33'd26, 0, f_at, l_at);
    repeat (6) step();
    check("t2_npk", pk_n, 2);
    check("t2_idx", peak_idx_o, 2);
    check("t2_mag", peak_mag_o, 25);
    check("t2_found", peak_found_o, 0);

    send_frame(33'd25, 0, f_at, l_at);
    repeat (6) step();
    check("t2b_found_eq", peak_found_o, 1);

    clear_vec();
    re_v[6] = -3;
    im_v[6] = 4;
    send_frame(33'd0, 0, f_at, l_at);
    repeat (6) step();
    check("t3_npk", pk_n, 4);
    check("t3_idx", peak_idx_o, 6);
    check("t3_mag", peak_mag_o, 25);

    clear_vec();
    re_v[3] = -32768;
    im_v[3] = -32768;
    send_frame(33'd0, 0, f_at, l_at);
    repeat (6) step();
    check("t4_idx", peak_idx_o, 3);
    check("t4_mag", peak_mag_o, 64'd2147483648);

    // Restart in the middle of a frame: the old frame's large bin must vanish.
    send(0, 0, 1'b1, 1'b0, 0, at);
    send(100, 0, 1'b0, 1'b0, 0, at);
    send(0, 0, 1'b0, 1'b0, 0, at);
    send(0, 0, 1'b0, 1'b0, 0, at);
    clear_vec();
    re_v[5] = 7;
    send_frame(33'd0, 0, f_at, l_at);
    repeat (6) step();
    check("t5_nerr", err_n, 1);
    check("t5_err_lat", last_err_cyc - f_at, 3);
    check("t5_npk", pk_n, 6);
    check("t5_idx", peak_idx_o, 5);
    check("t5_mag", peak_mag_o, 49);

    // Early eob: error only, outputs keep the previous peak.
    send(1, 0, 1'b1, 1'b0, 0, at);
    for (int b = 1; b < 5; b++) send(0, 0, 1'b0, 1'b0, 0, at);
    send(50, 0, 1'b0, 1'b1, 0, at);
    repeat (6) step();
    check("t6_nerr", err_n, 2);
    check("t6_err_lat", last_err_cyc - at, 3);
    check("t6_npk", pk_n, 6);
    check("t6_hold_idx", peak_idx_o, 5);
    check("t6_hold_mag", peak_mag_o, 49);

    // Nine beats without eob: error on the 8th, 9th ignored.
    send(0, 0, 1'b1, 1'b0, 0, at);
    for (int b = 1; b < 9; b++) begin
      send(0, 0, 1'b0, 1'b0, 0, at);
      if (b == 7) at7 = at;
    end
    repeat (6) step();
    check("t7_nerr", err_n, 3);
    check("t7_err_lat", last_err_cyc - at7, 3);
    check("t7_npk", pk_n, 6);

    send(0, 0, 1'b0, 1'b1, 2, at);
    check("t8_eob_idle", err_n, 4);
    send(0, 0, 1'b1, 1'b1, 2, at);
    repeat (4) step();
    check("t8_sob_eob", err_n, 5);
    check("t8_npk", pk_n, 6);

    // Back-to-back frames with random gaps inside each frame.
    re_v = '{1, 9, 2, 0, 0, 0, 0, -9};
    im_v = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(33'd0, 3, f_at, l_at);
    clear_vec();
    im_v[6] = -10;
    im_v[7] = 11;
    send_frame(33'd0, 3, f_at, l_at);
    repeat (6) step();
    check("t9_npk", pk_n, 8);
    check("t9a_idx", pk_idx_a[6], 1);
    check("t9a_mag", pk_mag_a[6], 81);
    check("t9b_idx", pk_idx_a[7], 7);
    check("t9b_mag", pk_mag_a[7], 121);
    check("t9b_lat", last_pk_cyc - l_at, 3);
    check("t9_nerr", err_n, 5);

    // Reset in the middle of a third frame.
    send(200, 0, 1'b1, 1'b0, 0, at);
    for (int b = 1; b < 4; b++) send(200, 0, 1'b0, 1'b0, 0, at);
    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
    repeat (6) step();
    check("t10_npk", pk_n, 8);
    check("t10_nerr", err_n, 5);
    check("t10_idx", peak_idx_o, 0);
    check("t10_mag", peak_mag_o, 0);

    re_v = '{0, 1, 5, 2, 5, 0, 0, 3};
    im_v = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(33'd0, 1, f_at, l_at);
    repeat (6) step();
    check("t11_npk", pk_n, 9);
    check("t11_idx", peak_idx_o, 2);
    check("t11_mag", peak_mag_o, 25);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
